ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
Sequencer and two-port round-robin arbiter for the 16x8 bus-attached RAM. It shares the RAM between port 0 (CPU fetch/execute) and port 1 (program loader / debug). It drives the RAM address, the ram_in/ram_out strobes and the controller's own bus write-drive enable, and it captures read data from the shared 8-bit bus. Each granted request becomes one fixed-length read or write transaction, completed with a one-cycle ack.

Parameters:
ADDR_W, 4, RAM address width (16 words)
DATA_W, 8, RAM/bus data width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req0  in  1  port 0 request (level)
we0  in  1  port 0: 1 = write, 0 = read; valid while req0 high
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 one-cycle completion pulse
req1  in  1  port 1 request (level)
we1  in  1  port 1 write enable
addr1  in  ADDR_W  port 1 address
wdata1  in  DATA_W  port 1 write data
ack1  out  1  port 1 one-cycle completion pulse
rdata  out  DATA_W  read data; valid in the ack cycle of a read, held until the next read completes
busy  out  1  high in any state other than IDLE
ram_add_4  out  ADDR_W  RAM address
ram_in  out  1  RAM write strobe; RAM writes bus value on the clk edge while high
ram_out  out  1  RAM read strobe; RAM drives bus combinationally while high
bus_wdata  out  DATA_W  data to place on the shared bus
bus_drive_en  out  1  top-level tri-state enable for bus_wdata
bus_rdata  in  DATA_W  current shared bus value

Behaviour:
- Reset (async, immediate): state=IDLE; ram_in=ram_out=bus_drive_en=0; ack0=ack1=0; busy=0; ram_add_4=0; bus_wdata=0; rdata=0; rr pointer=port 0 favoured. A transaction in flight is abandoned: no ack, no strobe glitch, and a partial write does not occur.
- States: IDLE -> SETUP -> ACCESS -> ACK -> IDLE. A transaction takes 4 cycles including the return IDLE cycle.
- IDLE:
  - Only one req high: grant it.
  - Both req high: grant the port the pointer favours, then set the pointer to favour the other port.
  - Single-requester grant: pointer is set to favour the non-granted port.
  - On grant, register port id, we, addr and wdata; go to SETUP. Neither req high: stay.
- SETUP: ram_add_4 = latched addr; all strobes 0 (address setup cycle).
- ACCESS:
  - Read: ram_out=1; rdata <= bus_rdata at the end of the cycle.
  - Write: bus_drive_en=1; bus_wdata=latched wdata; ram_in=1 for exactly this cycle.
  - ram_in and ram_out are never both high. Both are 0 outside ACCESS.
- ACK: ack of the granted port =1 for exactly one cycle; the other ack stays 0; ram_add_4 is held. Next state is IDLE unconditionally.
- Strobe and ack outputs are registered (decoded from the state register); none is combinational from req inputs.
- Requester protocol: hold req/we/addr/wdata stable until ack is sampled, then deassert req on that edge. Inputs are sampled only in IDLE. Changes after grant are ignored.
- A req that drops mid-transaction still completes the transaction and still pulses ack.
- A req still high in the IDLE cycle after ack is treated as a new request.
- Latency: req first seen high at edge T (in IDLE) -> ack high in the cycle after edge T+2. Reads: rdata valid in that same cycle.
- Address wraps naturally at ADDR_W; no range checking.

Test Plan:
- After rst pulse -> all outputs 0, busy=0. Port 0 read addr 4'd3 with RAM reset contents -> ram_out high for exactly 1 cycle; ack0 in 3rd cycle after grant; rdata=8'h88.
- Port 1 write addr 4'd5 data 8'hA5, then port 0 read addr 5 -> ram_in and bus_drive_en high together for exactly 1 cycle; bus_wdata=8'hA5; read returns 8'hA5.
- req0 and req1 both held high continuously, each port reading a distinct address -> grants alternate 0,1,0,1; each ack pulse is 1 cycle; no two consecutive acks on the same port; 4 cycles per transaction.
- req1 only, 3 back-to-back writes to addrs 0,1,2 -> port 1 granted every time; pointer never starves it; then both requests high -> port 0 granted first.
- rst asserted during ACCESS of a write to addr 7 -> ram_in drops asynchronously, no ack, state IDLE. Subsequent read of addr 7 returns the reset value 8'hFF.
- req0 read dropped during SETUP -> transaction completes; ack0 pulses once; controller returns to IDLE and stays there (busy=0).

Source files
------------

// File: rtl/ram_access_ctrl.sv
// Two-port round-robin arbiter and access sequencer for the 16x8 bus RAM.
// Each grant runs IDLE -> SETUP -> ACCESS -> ACK with registered strobes.
module ram_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_add_4,
    output logic              ram_in,
    output logic              ram_out,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_drive_en,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    state_t            state;
    logic              rr;
    logic              port_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;

    logic              gnt_valid;
    logic              gnt_port;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;

    // Arbitration: single requester wins, a tie goes to the favoured port
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_port  = (req0 & req1) ? rr : req1;
        gnt_we    = gnt_port ? we1 : we0;
        gnt_addr  = gnt_port ? addr1 : addr0;
        gnt_wdata = gnt_port ? wdata1 : wdata0;
    end

    // Sequencer: state, request capture and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr           <= 1'b0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
            ram_add_4    <= '0;
            ram_in       <= 1'b0;
            ram_out      <= 1'b0;
            bus_wdata    <= '0;
            bus_drive_en <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (gnt_valid) begin
                        port_q    <= gnt_port;
                        we_q      <= gnt_we;
                        wdata_q   <= gnt_wdata;
                        ram_add_4 <= gnt_addr;
                        rr        <= ~gnt_port;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (we_q) begin
                        ram_in       <= 1'b1;
                        bus_drive_en <= 1'b1;
                        bus_wdata    <= wdata_q;
                    end else begin
                        ram_out <= 1'b1;
                    end
                    state <= ACCESS;
                end
                ACCESS: begin
                    ram_in       <= 1'b0;
                    ram_out      <= 1'b0;
                    bus_drive_en <= 1'b0;
                    bus_wdata    <= '0;
                    if (!we_q) begin
                        rdata <= bus_rdata;
                    end
                    ack0  <= ~port_q;
                    ack1  <= port_q;
                    state <= ACK;
                end
                ACK: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural 16x8 bus RAM.
// Vector table for single transactions plus hand sequences for corners.
module tb_ram_access_ctrl;

    logic       clk;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata;
    logic [3:0] ram_add_4;
    logic       ram_in, ram_out, bus_drive_en;
    logic [7:0] bus_wdata, bus_rdata;

    int n_cmp;
    int n_bad;

    logic       ram_load;
    logic [7:0] mem [16];

    ram_access_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .ram_add_4(ram_add_4),
        .ram_in(ram_in), .ram_out(ram_out),
        .bus_wdata(bus_wdata), .bus_drive_en(bus_drive_en),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Shared bus: controller drive wins, else RAM drives when read-strobed
    assign bus_rdata = bus_drive_en ? bus_wdata :
                       (ram_out ? mem[ram_add_4] : 8'h00);

    // RAM: power-on contents on load, write bus value while ram_in high
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
            mem[3] <= 8'h88;
            mem[7] <= 8'hFF;
        end else if (ram_in) begin
            mem[ram_add_4] <= bus_rdata;
        end
    end

    typedef struct {
        logic       port;
        logic       we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int   cyc, rin, rout, drv, bad_bus;
        logic got;
        string tag;
        cyc = 0; rin = 0; rout = 0; drv = 0; bad_bus = 0; got = 0;
        tag = $sformatf("vec%0d", idx);
        if (v.port) begin
            req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
        end
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (ram_in) begin
                rin++;
                if (bus_wdata !== v.wdata) bad_bus++;
            end
            if (ram_out) rout++;
            if (bus_drive_en) drv++;
            if (ram_in && ram_out) bad_bus++;
            if (ack0 || ack1) got = 1;
        end
        req0 = 0;
        req1 = 0;
        check({tag, "_latency"}, cyc, 3);
        check({tag, "_ack"}, {ack1, ack0}, v.port ? 2'b10 : 2'b01);
        check({tag, "_rdata"}, rdata, v.exp_rdata);
        check({tag, "_ram_in_cnt"}, rin, v.we ? 1 : 0);
        check({tag, "_ram_out_cnt"}, rout, v.we ? 0 : 1);
        check({tag, "_drive_cnt"}, drv, v.we ? 1 : 0);
        check({tag, "_bus"}, bad_bus, 0);
        @(negedge clk);
        check({tag, "_idle"}, {busy, ack1, ack0}, 3'b000);
    endtask

    initial begin
        int   n_a0, n_a1;
        logic e0, e1;
        logic [7:0] rd_at_ack;
        n_cmp = 0; n_bad = 0;
        clk = 0; rst = 1; ram_load = 1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        vecs[0] = '{1'b0, 1'b0, 4'd3,  8'h00, 8'h88};
        vecs[1] = '{1'b1, 1'b1, 4'd5,  8'hA5, 8'h88};
        vecs[2] = '{1'b0, 1'b0, 4'd5,  8'h00, 8'hA5};
        vecs[3] = '{1'b1, 1'b0, 4'd15, 8'h00, 8'h1F};
        vecs[4] = '{1'b1, 1'b1, 4'd0,  8'h11, 8'h1F};
        vecs[5] = '{1'b1, 1'b1, 4'd1,  8'h22, 8'h1F};
        vecs[6] = '{1'b1, 1'b1, 4'd2,  8'h33, 8'h1F};

        @(negedge clk);
        @(negedge clk);
        check("reset_outputs",
              {ack0, ack1, busy, ram_in, ram_out, bus_drive_en,
               rdata, ram_add_4, bus_wdata}, 0);
        ram_load = 0;
        rst = 0;
        @(negedge clk);
        check("reset_idle", {busy, ack1, ack0}, 3'b000);

        for (int i = 0; i < 7; i++) do_txn(i, vecs[i]);

        // Both ports request continuously: grants alternate 0,1,0,1
        req0 = 1; we0 = 0; addr0 = 4'd0;
        req1 = 1; we1 = 0; addr1 = 4'd2;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            e0 = (k % 4 == 3) && ((k / 4) % 2 == 0);
            e1 = (k % 4 == 3) && ((k / 4) % 2 == 1);
            check($sformatf("rr_ack_k%0d", k), {ack1, ack0}, {e1, e0});
            check($sformatf("rr_busy_k%0d", k), busy, (k % 4) != 0);
            if (e0) check($sformatf("rr_rdata0_k%0d", k), rdata, 8'h11);
            if (e1) check($sformatf("rr_rdata1_k%0d", k), rdata, 8'h33);
            if (k == 15) begin
                req0 = 0;
                req1 = 0;
            end
        end
        @(negedge clk);
        check("rr_end_idle", {busy, ack1, ack0}, 3'b000);

        // Reset in the ACCESS cycle of a write aborts it cleanly
        req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 8'h5A;
        @(negedge clk);
        @(negedge clk);
        check("abort_ram_in_before", ram_in, 1'b1);
        #1 rst = 1;
        #1;
        check("abort_async",
              {ram_in, ram_out, bus_drive_en, busy, ack1, ack0}, 6'b0);
        req0 = 0; we0 = 0;
        @(negedge clk);
        rst = 0;
        n_a0 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) n_a0++;
        end
        check("abort_no_ack", n_a0, 0);
        vecs[0] = '{1'b0, 1'b0, 4'd7, 8'h00, 8'hFF};
        do_txn(7, vecs[0]);

        // req0 read dropped during SETUP still completes once
        req0 = 1; we0 = 0; addr0 = 4'd3;
        @(negedge clk);
        req0 = 0;
        n_a0 = 0; n_a1 = 0; rd_at_ack = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack0) begin
                n_a0++;
                rd_at_ack = rdata;
            end
            if (ack1) n_a1++;
        end
        check("drop_ack0_cnt", n_a0, 1);
        check("drop_ack1_cnt", n_a1, 0);
        check("drop_rdata", rd_at_ack, 8'h88);
        check("drop_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
